zx_keymatrix: RTL and testbench
===============================

# zx_keymatrix

PS/2 keyboard front end for the Spectrum ULA. It deserialises PS/2 frames, decodes make, break and extended scancodes, and maintains the 8×5 Spectrum key matrix. It answers the ULA's port-FE read with the active-low column bits for the rows selected by A[15:8]. It sits directly upstream of the ULA read mux and drives KEYB[4:0], F1 and F11.

## Interface
- TIMEOUT, 28000: CLK cycles with no PS2_CLK falling edge before a partial frame is discarded (2 ms at 14 MHz).
- FILTER, 8: consecutive identical samples needed before a filtered PS2_CLK level changes.
- CLK  in  1  ULA clock, 14 MHz; all state on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- PS2_CLK  in  1  raw PS/2 clock, asynchronous.
- PS2_DAT  in  1  raw PS/2 data, asynchronous.
- A  in  16  CPU address bus; only A[15:8] is used, as active-low row selects.
- KEYB  out  5  column bits, active-low; 1 = no key pressed.
- F1  out  1  high while F1 is held.
- F11  out  1  high while F11 is held.

## Operation
- Reset values: matrix all released; KEYB = 5'b11111; F1 = F11 = 0; prefix flags cleared; receiver idle with bit count 0.
- Input conditioning:
  - PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser.
  - PS2_CLK then passes the FILTER-sample glitch filter.
  - A falling edge of the filtered clock samples the synchronised PS2_DAT.
- Frame format: 11 bits, LSB first: start (0), 8 data bits, odd parity, stop (1).
  - The frame is accepted only if start = 0, parity is odd and stop = 1.
  - Any violation discards the frame and clears both prefix flags.
- Timeout: if the bit count is nonzero and TIMEOUT cycles pass without a falling edge, the bit count returns to 0. Prefix flags are kept.
- Decoder, applied to each accepted byte:
  - 0xF0 sets `rel`.
  - 0xE0 sets `ext`.
  - Any other byte is looked up as {ext, code}:
    - If mapped, every matrix bit mapped to that code is set (rel = 0) or cleared (rel = 1).
    - Unmapped codes change nothing.
    - In both cases, `rel` and `ext` are cleared afterwards.
- Matrix rows and columns: row r is selected by A[8+r] = 0; column c drives KEYB[c].
  - Row 0: CS Z X C V
  - Row 1: A S D F G
  - Row 2: Q W E R T
  - Row 3: 1 2 3 4 5
  - Row 4: 0 9 8 7 6
  - Row 5: P O I U Y
  - Row 6: Enter L K J H
  - Row 7: Space SS M N B
- Compound keys set or clear two matrix bits together:
  - Backspace 0x66 = CS + 0.
  - Arrows E0 6B / 74 / 75 / 72 = CS+5 / CS+8 / CS+7 / CS+6.
  - Left and right shift (0x12, 0x59) both map to CS; Ctrl 0x14 maps to SS.
  - E0 12 (fake shift) is unmapped.
- F1 (0x05) and F11 (0x78) drive only their level outputs, not the matrix.
- KEYB[c] = ~OR over all selected rows r of matrix[r][c]. With multiple rows selected, results are ANDed (active-low). With no row selected, KEYB = 5'b11111.

## Timing
- KEYB is combinational from A and the registered matrix, so it is valid in the same cycle A changes.
- Matrix and F-key outputs update 1 CLK after the cycle in which the stop bit is sampled. The receiver issues a 1-cycle `valid` strobe; the decoder applies the byte on the next edge.
- Minimum edge-to-sample latency: 2 synchroniser cycles + FILTER cycles.
- Only one byte can complete per cycle. Decoder state changes only on `valid`, so an incoming byte and a timeout never conflict: timeout fires only while the frame is partial.
- nRESET asserted mid-frame clears the receiver and matrix immediately. After release, the receiver waits for the next start bit, and a trailing partial frame dies by timeout.
- A release of a code never pressed is harmless: the bits are already clear.

## Structure
- Package `zx_kbd_pkg` holds:
  - Scancode constants (PREFIX_REL = 8'hF0, PREFIX_EXT = 8'hE0, SC_F1, SC_F11).
  - A typedef for a {row[2:0], col[2:0], valid} key location.
  - A function mapping a 9-bit {ext, code} to two key locations (the second invalid for single keys).
- Sub-module `ps2_rx` contains the synchroniser, filter, shift register, parity and stop check, and timeout. It outputs `valid` (1-cycle strobe) and `data[7:0]`.
- The top level holds the decoder flags, the 40-bit matrix, the F-key registers and the column-reduce logic.

## Test plan
- Send frame 0x1C, then set A = 16'hFDFE → KEYB = 5'b11110. Send F0 1C → KEYB = 5'b11111.
- Send 0x66 and read A = 16'hFEFE and 16'hEFFE → KEYB = 5'b11110 on both (CS and 0). Send F0 66 → both 5'b11111.
- Send E0 75 → CS plus 7 pressed (A = 16'hEFFE gives KEYB = 5'b10111). Send E0 F0 75 → all released.
- Send 0x1C with even parity → no matrix change. The next valid 0x29 with A = 16'h7FFE → KEYB = 5'b11110.
- Send 6 bits, idle for TIMEOUT+10 cycles, then a full 0x05 → F1 = 1. Send F0 05 → F1 = 0.
- Press 0x1C and 0x29, then pulse nRESET low for 1 cycle → KEYB = 5'b11111 with A = 16'h0000, and F1 = F11 = 0.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zx_kbd_pkg
//  Description : Shared constants, key-location types and the PS/2 set-2
//                scancode to Spectrum matrix map for the ZX keyboard front
//                end.
//  Contents    : PREFIX_REL / PREFIX_EXT / SC_F1 / SC_F11 scancodes,
//                key_loc_t {row, col, valid}, key_pair_t, key_map().
//  Revision    : 1.0  initial release
// ============================================================================
package zx_kbd_pkg;

  localparam logic [7:0] PREFIX_REL = 8'hF0;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] SC_F1      = 8'h05;
  localparam logic [7:0] SC_F11     = 8'h78;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       valid;
  } key_loc_t;

  // Compound keys touch two matrix bits; single keys leave k1 invalid.
  typedef struct packed {
    key_loc_t k0;
    key_loc_t k1;
  } key_pair_t;

  function automatic key_loc_t mk(input int r, input int c);
    key_loc_t k;
    k.row   = 3'(r);
    k.col   = 3'(c);
    k.valid = 1'b1;
    return k;
  endfunction

  // Argument is {ext, code}; bit 8 set means the code followed an E0 prefix.
  function automatic key_pair_t key_map(input logic [8:0] sc);
    key_pair_t p;
    p = '0;
    case (sc)
      // Row 0: CS Z X C V (both shifts act as CAPS SHIFT)
      9'h012, 9'h059: p.k0 = mk(0, 0);
      9'h01A: p.k0 = mk(0, 1);
      9'h022: p.k0 = mk(0, 2);
      9'h021: p.k0 = mk(0, 3);
      9'h02A: p.k0 = mk(0, 4);
      // Row 1: A S D F G
      9'h01C: p.k0 = mk(1, 0);
      9'h01B: p.k0 = mk(1, 1);
      9'h023: p.k0 = mk(1, 2);
      9'h02B: p.k0 = mk(1, 3);
      9'h034: p.k0 = mk(1, 4);
      // Row 2: Q W E R T
      9'h015: p.k0 = mk(2, 0);
      9'h01D: p.k0 = mk(2, 1);
      9'h024: p.k0 = mk(2, 2);
      9'h02D: p.k0 = mk(2, 3);
      9'h02C: p.k0 = mk(2, 4);
      // Row 3: 1 2 3 4 5
      9'h016: p.k0 = mk(3, 0);
      9'h01E: p.k0 = mk(3, 1);
      9'h026: p.k0 = mk(3, 2);
      9'h025: p.k0 = mk(3, 3);
      9'h02E: p.k0 = mk(3, 4);
      // Row 4: 0 9 8 7 6
      9'h045: p.k0 = mk(4, 0);
      9'h046: p.k0 = mk(4, 1);
      9'h03E: p.k0 = mk(4, 2);
      9'h03D: p.k0 = mk(4, 3);
      9'h036: p.k0 = mk(4, 4);
      // Row 5: P O I U Y
      9'h04D: p.k0 = mk(5, 0);
      9'h044: p.k0 = mk(5, 1);
      9'h043: p.k0 = mk(5, 2);
      9'h03C: p.k0 = mk(5, 3);
      9'h035: p.k0 = mk(5, 4);
      // Row 6: Enter L K J H
      9'h05A: p.k0 = mk(6, 0);
      9'h04B: p.k0 = mk(6, 1);
      9'h042: p.k0 = mk(6, 2);
      9'h03B: p.k0 = mk(6, 3);
      9'h033: p.k0 = mk(6, 4);
      // Row 7: Space SS M N B (Ctrl acts as SYMBOL SHIFT)
      9'h029: p.k0 = mk(7, 0);
      9'h014: p.k0 = mk(7, 1);
      9'h03A: p.k0 = mk(7, 2);
      9'h031: p.k0 = mk(7, 3);
      9'h032: p.k0 = mk(7, 4);
      // Compound keys: CAPS SHIFT plus a digit
      9'h066: begin p.k0 = mk(0, 0); p.k1 = mk(4, 0); end  // Backspace
      9'h16B: begin p.k0 = mk(0, 0); p.k1 = mk(3, 4); end  // Left  = CS+5
      9'h172: begin p.k0 = mk(0, 0); p.k1 = mk(4, 4); end  // Down  = CS+6
      9'h175: begin p.k0 = mk(0, 0); p.k1 = mk(4, 3); end  // Up    = CS+7
      9'h174: begin p.k0 = mk(0, 0); p.k1 = mk(4, 2); end  // Right = CS+8
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host receiver. Synchronises and glitch-filters
//                the PS/2 lines, shifts in 11-bit frames on falling clock
//                edges, checks start/parity/stop and drops partial frames
//                after TIMEOUT idle cycles.
//  Ports       : clk_i, rst_ni     - clock, async active-low reset
//                ps2_clk_i/_dat_i  - raw asynchronous PS/2 lines
//                valid_o           - 1-cycle strobe, data_o holds the byte
//                err_o             - 1-cycle strobe on a rejected frame
//                data_o[7:0]       - last accepted byte
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx #(
  parameter int TIMEOUT = 28000,
  parameter int FILTER  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       valid_o,
  output logic       err_o,
  output logic [7:0] data_o
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    sr_q, sr_d;
  logic [TW-1:0] to_q, to_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [7:0]    data_q, data_d;

  logic          w_dat, w_fall;
  logic [10:0]   w_frame;

  assign w_dat  = dat_sync_q[1];
  // The filtered clock is about to flip from 1 to 0: that is the sample point.
  assign w_fall = filt_q & ~clk_sync_q[1] & (fcnt_q == FW'(FILTER - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      // Level changes only after FILTER consecutive samples disagree with it.
      if (clk_sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER - 1)) begin
        filt_q <= clk_sync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    to_d    = to_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    w_frame = {w_dat, sr_q};
    if (w_fall) begin
      to_d = '0;
      if (cnt_q == 4'd0) begin
        // Idle: a high bit cannot be a start bit, so stay aligned.
        if (!w_dat) begin
          cnt_d = 4'd1;
          sr_d  = {w_dat, sr_q[9:1]};
        end
      end else if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        if (!w_frame[0] && (^w_frame[9:1]) && w_frame[10]) begin
          valid_d = 1'b1;
          data_d  = w_frame[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
        sr_d  = {w_dat, sr_q[9:1]};
      end
    end else if (cnt_q != 4'd0) begin
      if (to_q == TW'(TIMEOUT - 1)) begin
        cnt_d = 4'd0;
        to_d  = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/zx_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : zx_keymatrix
//  Description : PS/2 keyboard front end for the Spectrum ULA. Decodes make,
//                break and extended scancodes into the 8x5 key matrix and
//                answers port-FE reads with active-low column bits.
//  Ports       : clk_i, rst_ni     - 14 MHz ULA clock, async active-low reset
//                ps2_clk_i/_dat_i  - raw PS/2 lines
//                a_i[15:0]         - CPU address; A[15:8] are row selects
//                keyb_o[4:0]       - active-low column bits
//                f1_o, f11_o       - high while F1 / F11 are held
//  Revision    : 1.0  initial release
// ============================================================================
module zx_keymatrix #(
  parameter int TIMEOUT = 28000,
  parameter int FILTER  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  input  logic [15:0] a_i,
  output logic [4:0]  keyb_o,
  output logic        f1_o,
  output logic        f11_o
);

  import zx_kbd_pkg::*;

  logic       rx_valid, rx_err;
  logic [7:0] rx_data;

  ps2_rx #(
    .TIMEOUT (TIMEOUT),
    .FILTER  (FILTER)
  ) u_rx (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .valid_o   (rx_valid),
    .err_o     (rx_err),
    .data_o    (rx_data)
  );

  // Matrix bit index is row*5 + col.
  logic [39:0] mat_q, mat_d;
  logic        rel_q, rel_d, ext_q, ext_d;
  logic        f1_q, f1_d, f11_q, f11_d;
  key_pair_t   w_keys;

  function automatic logic [5:0] bit_idx(input key_loc_t k);
    return ({3'b000, k.row} * 6'd5) + {3'b000, k.col};
  endfunction

  assign w_keys = key_map({ext_q, rx_data});

  always_comb begin
    mat_d = mat_q;
    rel_d = rel_q;
    ext_d = ext_q;
    f1_d  = f1_q;
    f11_d = f11_q;
    if (rx_err) begin
      rel_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_data == PREFIX_REL) begin
        rel_d = 1'b1;
      end else if (rx_data == PREFIX_EXT) begin
        ext_d = 1'b1;
      end else begin
        if (w_keys.k0.valid) mat_d[bit_idx(w_keys.k0)] = ~rel_q;
        if (w_keys.k1.valid) mat_d[bit_idx(w_keys.k1)] = ~rel_q;
        if (!ext_q && rx_data == SC_F1)  f1_d  = ~rel_q;
        if (!ext_q && rx_data == SC_F11) f11_d = ~rel_q;
        rel_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mat_q <= '0;
      rel_q <= 1'b0;
      ext_q <= 1'b0;
      f1_q  <= 1'b0;
      f11_q <= 1'b0;
    end else begin
      mat_q <= mat_d;
      rel_q <= rel_d;
      ext_q <= ext_d;
      f1_q  <= f1_d;
      f11_q <= f11_d;
    end
  end

  // Column reduce: OR the pressed bits of every selected row, then invert.
  logic [7:0][4:0] w_row_hit;
  logic [4:0]      w_cols;

  for (genvar r = 0; r < 8; r++) begin : g_row
    assign w_row_hit[r] = a_i[8+r] ? 5'b00000 : mat_q[r*5 +: 5];
  end

  always_comb begin
    w_cols = '0;
    for (int r = 0; r < 8; r++) w_cols = w_cols | w_row_hit[r];
  end

  assign keyb_o = ~w_cols;
  assign f1_o   = f1_q;
  assign f11_o  = f11_q;

  // The low address byte carries no row information.
  logic w_unused_addr;
  assign w_unused_addr = ^a_i[7:0];

endmodule
`default_nettype wire

// File: tb/tb_zx_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zx_keymatrix
//  Description : Self-checking bench for zx_keymatrix. A behavioural model of
//                the key matrix (scancode table + prefix flags) predicts
//                KEYB/F1/F11 every cycle; directed literal checks pin it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_zx_keymatrix;

  localparam int TIMEOUT = 3000;
  localparam int FILTER  = 8;
  localparam int HALF    = 20;   // CLK cycles per PS/2 clock half period

  logic        clk = 1'b0;
  logic        rst_n, ps2_clk, ps2_dat;
  logic [15:0] a;
  logic [4:0]  keyb;
  logic        f1, f11;

  always #5 clk = ~clk;

  zx_keymatrix #(.TIMEOUT(TIMEOUT), .FILTER(FILTER)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .a_i       (a),
    .keyb_o    (keyb),
    .f1_o      (f1),
    .f11_o     (f11)
  );

  int total = 0;
  int bad   = 0;
  bit busy  = 1'b1;
  bit rand_a = 1'b0;

  // ---------------- behavioural model ----------------
  logic [7:0] keytab [8][5] = '{
    '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
  };
  logic [7:0] extras [10] = '{8'h05, 8'h78, 8'h66, 8'h59, 8'h6B,
                              8'h74, 8'h75, 8'h72, 8'h12, 8'h14};

  bit m_mat [8][5];
  bit m_rel, m_ext, m_f1, m_f11;

  task automatic model_clear();
    foreach (m_mat[r, c]) m_mat[r][c] = 1'b0;
    m_rel = 0; m_ext = 0; m_f1 = 0; m_f11 = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit v;
    if (b == 8'hF0) m_rel = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      v = !m_rel;
      if (!m_ext) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 5; c++)
            if (keytab[r][c] == b) m_mat[r][c] = v;
        if (b == 8'h59) m_mat[0][0] = v;
        if (b == 8'h66) begin m_mat[0][0] = v; m_mat[4][0] = v; end
        if (b == 8'h05) m_f1 = v;
        if (b == 8'h78) m_f11 = v;
      end else begin
        case (b)
          8'h6B: begin m_mat[0][0] = v; m_mat[3][4] = v; end
          8'h74: begin m_mat[0][0] = v; m_mat[4][2] = v; end
          8'h75: begin m_mat[0][0] = v; m_mat[4][3] = v; end
          8'h72: begin m_mat[0][0] = v; m_mat[4][4] = v; end
          default: ;
        endcase
      end
      m_rel = 0; m_ext = 0;
    end
  endtask

  function automatic logic [4:0] exp_keyb(input logic [15:0] addr);
    logic [4:0] k;
    k = 5'b11111;
    for (int r = 0; r < 8; r++)
      if (!addr[8+r])
        for (int c = 0; c < 5; c++)
          if (m_mat[r][c]) k[c] = 1'b0;
    return k;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (a=%h t=%0t)", nm, got, exp, a, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!busy && rst_n) begin
        check("cyc_keyb", 16'(keyb), 16'(exp_keyb(a)));
        check("cyc_f1",   16'(f1),   16'(m_f1));
        check("cyc_f11",  16'(f11),  16'(m_f11));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badpar);
    return {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_a) a = 16'($urandom);
      ps2_dat = fr[i];
      repeat (HALF) @(posedge clk);
      if (i == n - 1) busy = 1'b1;
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mkframe(b, 1'b0), 11);
    model_byte(b);
    busy = 1'b0;
  endtask

  task automatic send_bad(input logic [7:0] b);
    send_bits(mkframe(b, 1'b1), 11);
    m_rel = 0; m_ext = 0;
    busy = 1'b0;
  endtask

  task automatic probe(input string nm, input logic [15:0] addr, input logic [4:0] exp);
    @(negedge clk);
    a = addr;
    #1;
    check(nm, 16'(keyb), 16'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    busy  = 1'b1;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    busy  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int unsigned r;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; a = 16'h0000;
    model_clear();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_keyb", 16'(keyb), 16'h001F);
    check("rst_f1",   16'(f1),   16'h0000);
    check("rst_f11",  16'(f11),  16'h0000);
    rst_n = 1'b1;
    busy  = 1'b0;

    // Single key press and release
    send_byte(8'h1C);
    probe("press_A", 16'hFDFE, 5'b11110);
    send_byte(8'hF0); send_byte(8'h1C);
    probe("release_A", 16'hFDFE, 5'b11111);

    // Backspace = CS + 0
    send_byte(8'h66);
    probe("bksp_cs", 16'hFEFE, 5'b11110);
    probe("bksp_0",  16'hEFFE, 5'b11110);
    send_byte(8'hF0); send_byte(8'h66);
    probe("bksp_rel_cs", 16'hFEFE, 5'b11111);
    probe("bksp_rel_0",  16'hEFFE, 5'b11111);

    // Extended arrow: up = CS + 7
    send_byte(8'hE0); send_byte(8'h75);
    probe("up_7",  16'hEFFE, 5'b10111);
    probe("up_cs", 16'hFEFE, 5'b11110);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    probe("up_rel", 16'h0000, 5'b11111);

    // Parity error discards, next frame is decoded normally
    send_bad(8'h1C);
    probe("badpar_A", 16'hFDFE, 5'b11111);
    send_byte(8'h29);
    probe("space", 16'h7FFE, 5'b11110);
    send_byte(8'hF0); send_byte(8'h29);

    // Randomised traffic against the model
    rand_a = 1'b1;
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = keytab[$urandom_range(0, 7)][$urandom_range(0, 4)];
      else if (r < 70) b = 8'hF0;
      else if (r < 78) b = 8'hE0;
      else if (r < 93) b = extras[$urandom_range(0, 9)];
      else             b = 8'($urandom);
      if ($urandom_range(0, 9) == 0) send_bad(b);
      else send_byte(b);
    end
    rand_a = 1'b0;
    pulse_reset();

    // Partial frame dies by timeout, then a full F1 frame is received
    send_bits(mkframe(8'h05, 1'b0), 6);
    busy = 1'b0;
    repeat (TIMEOUT + 10) @(posedge clk);
    send_byte(8'h05);
    @(negedge clk); check("f1_after_to", 16'(f1), 16'h0001);
    send_byte(8'hF0); send_byte(8'h05);
    @(negedge clk); check("f1_release", 16'(f1), 16'h0000);

    // Reset with keys held
    send_byte(8'h1C); send_byte(8'h29); send_byte(8'h78);
    @(negedge clk); check("f11_held", 16'(f11), 16'h0001);
    probe("held_all", 16'h0000, 5'b11110);
    pulse_reset();
    probe("post_rst_keyb", 16'h0000, 5'b11111);
    check("post_rst_f1",  16'(f1),  16'h0000);
    check("post_rst_f11", 16'(f11), 16'h0000);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
